wb_ddr3_arb: RTL and testbench

- Two-master Wishbone arbiter in front of the single 128-bit Wishbone DDR3 slave port.
- Masters are m0 (CPU data/instruction path) and m1 (DMA/video engine). Both run in the DDR user clock domain.
- Grants the slave to one master at a time, with round-robin fairness and a hold limit.
- Withholds grants until DDR calibration completes. Aborts stuck transfers with a watchdog that returns an error.

---
 rtl/wb_ddr3_arb.sv | 171 +++++++++++++++++
 tb/tb_wb_ddr3_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ddr3_arb.sv
// Two-master Wishbone arbiter in front of the 128-bit DDR3 slave port.
// Round-robin or fixed-priority grant, per-grant hold limit, calibration gate
// and a stuck-transfer watchdog that returns err to the owning master.
module wb_ddr3_arb #(
    parameter int unsigned MAX_HOLD    = 4,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned PRIO_M0     = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_cpl,

    input  logic         m0_cyc_i,
    input  logic         m0_stb_i,
    input  logic         m0_we_i,
    input  logic [31:0]  m0_adr_i,
    input  logic [15:0]  m0_sel_i,
    input  logic [127:0] m0_dat_i,
    output logic [127:0] m0_dat_o,
    output logic         m0_ack_o,
    output logic         m0_err_o,

    input  logic         m1_cyc_i,
    input  logic         m1_stb_i,
    input  logic         m1_we_i,
    input  logic [31:0]  m1_adr_i,
    input  logic [15:0]  m1_sel_i,
    input  logic [127:0] m1_dat_i,
    output logic [127:0] m1_dat_o,
    output logic         m1_ack_o,
    output logic         m1_err_o,

    output logic         s_cyc_o,
    output logic         s_stb_o,
    output logic         s_we_o,
    output logic [31:0]  s_adr_o,
    output logic [15:0]  s_sel_o,
    output logic [127:0] s_dat_o,
    input  logic [127:0] s_dat_i,
    input  logic         s_ack_i,

    output logic [1:0]   grant_o,
    output logic [7:0]   timeout_cnt_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic [7:0]  timeout_cnt_q, timeout_cnt_d;

    logic busy, in_err, req0, req1, fwd_ack;
    logic own_cyc, own_stb, own_we;
    logic [31:0]  own_adr;
    logic [15:0]  own_sel;
    logic [127:0] own_dat;

    assign busy   = (state_q == StBusy);
    assign in_err = (state_q == StErr);
    assign req0   = m0_cyc_i & m0_stb_i;
    assign req1   = m1_cyc_i & m1_stb_i;

    // Select the current owner's bus signals
    always_comb begin
        own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
        own_stb = owner_q ? m1_stb_i : m0_stb_i;
        own_we  = owner_q ? m1_we_i  : m0_we_i;
        own_adr = owner_q ? m1_adr_i : m0_adr_i;
        own_sel = owner_q ? m1_sel_i : m0_sel_i;
        own_dat = owner_q ? m1_dat_i : m0_dat_i;
    end

    // Slave-side outputs are live only while a master holds the grant
    always_comb begin
        s_cyc_o = busy & own_cyc;
        s_stb_o = busy & own_stb;
        s_we_o  = busy & own_we;
        s_adr_o = busy ? own_adr : '0;
        s_sel_o = busy ? own_sel : '0;
        s_dat_o = busy ? own_dat : '0;
    end

    // Acks reach only the owner; late acks outside BUSY or after calibration loss are dropped
    assign fwd_ack = busy & s_ack_i & init_cpl;

    // Master-side completion, error and read-data routing
    always_comb begin
        m0_ack_o = fwd_ack & ~owner_q;
        m1_ack_o = fwd_ack & owner_q;
        m0_err_o = in_err & ~owner_q;
        m1_err_o = in_err & owner_q;
        m0_dat_o = (busy & (~owner_q | s_ack_i)) ? s_dat_i : '0;
        m1_dat_o = (busy & (owner_q | s_ack_i))  ? s_dat_i : '0;
        grant_o  = (busy | in_err) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        timeout_cnt_o = timeout_cnt_q;
    end

    // Arbitration, hold limit and watchdog next-state
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        hold_cnt_d    = hold_cnt_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (init_cpl && (req0 || req1)) begin
                    if (req0 && req1) begin
                        owner_d = (PRIO_M0 != 0) ? 1'b0 : ~last_owner_q;
                    end else begin
                        owner_d = req1;
                    end
                    hold_cnt_d = '0;
                    wd_cnt_d   = '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (!init_cpl || !own_cyc) begin
                    state_d      = StIdle;
                    last_owner_d = owner_q;
                end else if (s_ack_i) begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                    wd_cnt_d   = '0;
                    if (MAX_HOLD != 0 && (hold_cnt_q + 32'd1) == MAX_HOLD) begin
                        state_d      = StIdle;
                        last_owner_d = owner_q;
                    end
                end else if (own_stb) begin
                    if (TIMEOUT_CYC != 0 && wd_cnt_q == TIMEOUT_CYC - 32'd1) begin
                        state_d = StErr;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 32'd1;
                    end
                end
            end
            StErr: begin
                if (timeout_cnt_q != 8'hFF) begin
                    timeout_cnt_d = timeout_cnt_q + 8'd1;
                end
                last_owner_d = owner_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; last_owner resets to m1 so m0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            hold_cnt_q    <= '0;
            wd_cnt_q      <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            hold_cnt_q    <= hold_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_ddr3_arb.sv
// Directed bench for wb_ddr3_arb: dut_a is round-robin with a 16-cycle watchdog,
// dut_b is fixed-priority m0; both share master-side stimulus.
module tb_wb_ddr3_arb;

    logic clk = 1'b0;
    logic rst, init_cpl;
    logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0]  m0_adr, m1_adr;
    logic [15:0]  m0_sel, m1_sel;
    logic [127:0] m0_dat, m1_dat, s_dat;

    logic a_auto, a_ack_man, a_s_ack;
    logic [127:0] a_m0_dat_o, a_m1_dat_o, a_s_dat_o;
    logic a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
    logic a_s_cyc, a_s_stb, a_s_we;
    logic [31:0] a_s_adr;
    logic [15:0] a_s_sel;
    logic [1:0]  a_grant;
    logic [7:0]  a_tcnt;

    logic b_s_ack;
    logic [127:0] b_m0_dat_o, b_m1_dat_o, b_s_dat_o;
    logic b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic b_s_cyc, b_s_stb, b_s_we;
    logic [31:0] b_s_adr;
    logic [15:0] b_s_sel;
    logic [1:0]  b_grant;
    logic [7:0]  b_tcnt;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] D0  = {8{16'h1111}};
    localparam logic [127:0] D1  = {8{16'h2222}};
    localparam logic [127:0] DA5 = {16{8'hA5}};

    always #5 clk = ~clk;

    // Slave models: single-cycle ack while strobed, or a hand-driven ack
    assign a_s_ack = a_auto ? (a_s_cyc & a_s_stb) : a_ack_man;
    assign b_s_ack = b_s_cyc & b_s_stb;

    wb_ddr3_arb #(.MAX_HOLD(4), .TIMEOUT_CYC(16), .PRIO_M0(0)) dut_a (
        .clk(clk), .rst(rst), .init_cpl(init_cpl),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(a_m0_dat_o),
        .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(a_m1_dat_o),
        .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr),
        .s_sel_o(a_s_sel), .s_dat_o(a_s_dat_o), .s_dat_i(s_dat), .s_ack_i(a_s_ack),
        .grant_o(a_grant), .timeout_cnt_o(a_tcnt)
    );

    wb_ddr3_arb #(.MAX_HOLD(4), .TIMEOUT_CYC(16), .PRIO_M0(1)) dut_b (
        .clk(clk), .rst(rst), .init_cpl(init_cpl),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(b_m0_dat_o),
        .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(b_m1_dat_o),
        .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr),
        .s_sel_o(b_s_sel), .s_dat_o(b_s_dat_o), .s_dat_i(s_dat), .s_ack_i(b_s_ack),
        .grant_o(b_grant), .timeout_cnt_o(b_tcnt)
    );

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic idle_masters();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; init_cpl = 1'b0; a_auto = 1'b0; a_ack_man = 1'b0;
        idle_masters();
        m0_adr = 32'h0; m1_adr = 32'h0; m0_sel = 16'hFFFF; m1_sel = 16'hFFFF;
        m0_dat = D0; m1_dat = D1; s_dat = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_grant !== 2'b00 || a_s_cyc !== 1'b0 || a_s_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus grant=%b cyc=%b stb=%b expected 00 0 0",
                     a_grant, a_s_cyc, a_s_stb);
        end
        checks++;
        if (a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0 || a_m0_err !== 1'b0 ||
            a_m1_err !== 1'b0 || a_tcnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_resp ack=%b%b err=%b%b tcnt=%0d expected all 0",
                     a_m0_ack, a_m1_ack, a_m0_err, a_m1_err, a_tcnt);
        end
    endtask

    task automatic test_init_gate();
        @(posedge clk); #1;
        rst = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (a_s_stb !== 1'b0 || a_grant !== 2'b00) begin
                errors++;
                $display("FAIL init_gate cyc%0d stb=%b grant=%b expected 0 00",
                         i, a_s_stb, a_grant);
            end
        end
        @(posedge clk); #1;
        init_cpl = 1'b1;
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b00) begin
            errors++;
            $display("FAIL init_latency grant=%b expected 00", a_grant);
        end
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b01 || a_s_stb !== 1'b1 || a_s_adr !== 32'h100 ||
            a_s_we !== 1'b0 || a_m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL init_grant grant=%b stb=%b adr=%h we=%b ack=%b expected 01 1 100 0 0",
                     a_grant, a_s_stb, a_s_adr, a_s_we, a_m0_ack);
        end
        a_ack_man = 1'b1; s_dat = DA5;
        #1;
        checks++;
        if (a_m0_ack !== 1'b1 || a_m0_dat_o !== DA5 || a_m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL read_data ack0=%b ack1=%b dat=%h expected 1 0 %h",
                     a_m0_ack, a_m1_ack, a_m0_dat_o, DA5);
        end
        @(posedge clk); #1;
        a_ack_man = 1'b0; s_dat = '0;
        idle_masters();
        repeat (3) @(posedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] pat [10];
        pat = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h200;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h300;
        a_auto = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (a_grant !== pat[i % 10]) begin
                errors++;
                $display("FAIL rr_grant cyc%0d got %b expected %b", i, a_grant, pat[i % 10]);
            end
            checks++;
            if (a_m0_ack !== (pat[i % 10] == 2'b01) || a_m1_ack !== (pat[i % 10] == 2'b10)) begin
                errors++;
                $display("FAIL rr_ack cyc%0d ack0=%b ack1=%b grant_exp=%b",
                         i, a_m0_ack, a_m1_ack, pat[i % 10]);
            end
            if (pat[i % 10] != 2'b00) begin
                checks++;
                if (a_s_dat_o !== ((pat[i % 10] == 2'b01) ? D0 : D1) ||
                    a_s_adr !== ((pat[i % 10] == 2'b01) ? 32'h200 : 32'h300)) begin
                    errors++;
                    $display("FAIL rr_mux cyc%0d adr=%h dat=%h", i, a_s_adr, a_s_dat_o);
                end
            end
        end
        @(posedge clk); #1;
        idle_masters();
        a_auto = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_fixed_prio();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (b_grant !== ((i % 5 == 0) ? 2'b00 : 2'b01) || b_m1_ack !== 1'b0) begin
                errors++;
                $display("FAIL prio_grant cyc%0d got %b ack1=%b expected %b 0",
                         i, b_grant, b_m1_ack, (i % 5 == 0) ? 2'b00 : 2'b01);
            end
        end
        @(posedge clk); #1;
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(negedge clk);
        checks++;
        if (b_grant !== 2'b00) begin
            errors++;
            $display("FAIL prio_gap got %b expected 00", b_grant);
        end
        @(negedge clk);
        checks++;
        if (b_grant !== 2'b10 || b_m1_ack !== 1'b1 || b_m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL prio_m1 grant=%b ack1=%b ack0=%b expected 10 1 0",
                     b_grant, b_m1_ack, b_m0_ack);
        end
        @(posedge clk); #1;
        idle_masters();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_timeout();
        a_auto = 1'b0; a_ack_man = 1'b0;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h400;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            checks++;
            if (a_grant !== ((i == 0) ? 2'b00 : 2'b10) || a_m1_err !== (i == 17) ||
                a_s_stb !== (i >= 1 && i <= 16) || a_m0_err !== 1'b0) begin
                errors++;
                $display("FAIL wd_seq cyc%0d grant=%b err1=%b err0=%b stb=%b",
                         i, a_grant, a_m1_err, a_m0_err, a_s_stb);
            end
        end
        @(posedge clk); #1;
        idle_masters();
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b00 || a_m1_err !== 1'b0 || a_tcnt !== 8'd1) begin
            errors++;
            $display("FAIL wd_after grant=%b err=%b tcnt=%0d expected 00 0 1",
                     a_grant, a_m1_err, a_tcnt);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        a_ack_man = 1'b1;
        @(negedge clk);
        checks++;
        if (a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL late_ack ack0=%b ack1=%b expected 0 0", a_m0_ack, a_m1_ack);
        end
        @(posedge clk); #1;
        a_ack_man = 1'b0;
        @(negedge clk);
        checks++;
        if (a_tcnt !== 8'd1) begin
            errors++;
            $display("FAIL wd_count got %0d expected 1", a_tcnt);
        end
    endtask

    task automatic test_init_drop();
        a_auto = 1'b0; a_ack_man = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h500;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b01 || a_s_cyc !== 1'b1 || a_s_we !== 1'b1) begin
            errors++;
            $display("FAIL drop_pre grant=%b cyc=%b we=%b expected 01 1 1",
                     a_grant, a_s_cyc, a_s_we);
        end
        @(posedge clk); #1;
        init_cpl = 1'b0; a_ack_man = 1'b1;
        @(negedge clk);
        checks++;
        if (a_m0_ack !== 1'b0 || a_m0_err !== 1'b0) begin
            errors++;
            $display("FAIL drop_noack ack=%b err=%b expected 0 0", a_m0_ack, a_m0_err);
        end
        @(posedge clk); #1;
        a_ack_man = 1'b0;
        @(negedge clk);
        checks++;
        if (a_s_cyc !== 1'b0 || a_grant !== 2'b00 || a_m0_err !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle cyc=%b grant=%b err=%b expected 0 00 0",
                     a_s_cyc, a_grant, a_m0_err);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        init_cpl = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b01) begin
            errors++;
            $display("FAIL drop_regrant got %b expected 01", a_grant);
        end
        a_ack_man = 1'b1;
        #1;
        checks++;
        if (a_m0_ack !== 1'b1) begin
            errors++;
            $display("FAIL drop_complete ack=%b expected 1", a_m0_ack);
        end
        @(posedge clk); #1;
        a_ack_man = 1'b0;
        idle_masters();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_async_reset();
        a_auto = 1'b0; a_ack_man = 1'b0;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h600;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        a_ack_man = 1'b1;
        #1;
        checks++;
        if (a_grant !== 2'b10 || a_m1_ack !== 1'b1) begin
            errors++;
            $display("FAIL ares_pre grant=%b ack1=%b expected 10 1", a_grant, a_m1_ack);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (a_grant !== 2'b00 || a_s_cyc !== 1'b0 || a_s_stb !== 1'b0 || a_s_we !== 1'b0 ||
            a_s_adr !== 32'h0 || a_m1_ack !== 1'b0 || a_m1_err !== 1'b0) begin
            errors++;
            $display("FAIL ares_drop grant=%b cyc=%b stb=%b we=%b adr=%h ack1=%b err1=%b",
                     a_grant, a_s_cyc, a_s_stb, a_s_we, a_s_adr, a_m1_ack, a_m1_err);
        end
        a_ack_man = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b01) begin
            errors++;
            $display("FAIL ares_tie got %b expected 01", a_grant);
        end
        @(posedge clk); #1;
        idle_masters();
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_round_robin();
        test_fixed_prio();
        test_timeout();
        test_init_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
